maxpool_relu: RTL and testbench

MAXPOOL_RELU -- requirements
Module: maxpool_relu

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/pool_row_buf.sv | 29 ++
 rtl/maxpool_relu.sv | 144 ++++++++++++++
 tb/tb_maxpool_relu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN layer defaults, pooling FSM state encoding and width helpers.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int H_DEF      = 28;
  localparam int W_DEF      = 28;
  localparam int OC_DEF     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

  // Keeps counter/index widths at least one bit for degenerate sizes such as OC=1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Row buffer holding the horizontal pair maxima of the even input row, one entry per pooled column.
module pool_row_buf
  import cnn_pkg::*;
#(
  parameter int  DEPTH  = W_DEF / 2,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int AW     = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Contents need no reset; the read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 signed max-pool over a channel-major raster stream of conv results.
// Define POOL_RELU_EN to clamp each input sample to max(sample,0) before pooling.
module maxpool_relu
  import cnn_pkg::*;
#(
  parameter int  H      = H_DEF,
  parameter int  W      = W_DEF,
  parameter int  OC     = OC_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int AW     = clog2_min1((H / 2) * (W / 2)),
  localparam int KW     = clog2_min1(OC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_addr,
  output logic [KW-1:0]     out_ch,
  output logic              ch_done,
  output logic              layer_done
);

  localparam int CW        = clog2_min1(W);
  localparam int RW        = clog2_min1(H);
  localparam int BD        = W / 2;
  localparam int BW        = clog2_min1(BD);
  localparam int LAST_ADDR = (H / 2) * (W / 2) - 1;

  pool_state_e state_q;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic signed [DATA_W-1:0] prev_q, sample, pair_max, pool_max, buf_rd_data;
  logic beat, last_c, last_r, last_k, buf_wr, buf_rd, emit;
  logic [BW-1:0] buf_idx;
  logic [AW-1:0] addr_d;

  logic              out_valid_q, ch_done_q, layer_done_q;
  logic [DATA_W-1:0] out_data_q;
  logic [AW-1:0]     out_addr_q;
  logic [KW-1:0]     out_ch_q;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef POOL_RELU_EN
  assign sample = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign sample = in_data;
`endif

  always_comb begin
    beat   = (state_q == ST_RUN) && in_valid;
    last_c = (c_q == CW'(W - 1));
    last_r = (r_q == RW'(H - 1));
    last_k = (k_q == KW'(OC - 1));
    c_d    = last_c ? '0 : c_q + 1'b1;
    r_d    = r_q;
    k_d    = k_q;
    if (last_c) begin
      r_d = last_r ? '0 : r_q + 1'b1;
      if (last_r) k_d = last_k ? '0 : k_q + 1'b1;
    end
    // Even row stores pair maxima; odd row prefetches the entry on the even column.
    buf_idx  = BW'(c_q >> 1);
    buf_wr   = beat && !r_q[0] && c_q[0];
    buf_rd   = beat && r_q[0] && !c_q[0];
    emit     = beat && r_q[0] && c_q[0];
    pair_max = smax(prev_q, sample);
    pool_max = smax(pair_max, buf_rd_data);
    addr_d   = AW'(int'(r_q >> 1) * BD + int'(c_q >> 1));
  end

  pool_row_buf #(
    .DEPTH (BD),
    .DATA_W(DATA_W)
  ) u_row_buf (
    .clk    (clk),
    .wr_en  (buf_wr),
    .wr_addr(buf_idx),
    .wr_data(pair_max),
    .rd_en  (buf_rd),
    .rd_addr(buf_idx),
    .rd_data(buf_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      c_q          <= '0;
      r_q          <= '0;
      k_q          <= '0;
      prev_q       <= '0;
      out_valid_q  <= 1'b0;
      ch_done_q    <= 1'b0;
      layer_done_q <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_ch_q     <= '0;
    end else begin
      out_valid_q  <= emit;
      ch_done_q    <= emit && (addr_d == AW'(LAST_ADDR));
      layer_done_q <= (state_q == ST_DONE);
      if (emit) begin
        out_data_q <= pool_max;
        out_addr_q <= addr_d;
        out_ch_q   <= k_q;
      end
      if (beat) begin
        prev_q <= sample;
        c_q    <= c_d;
        r_q    <= r_d;
        k_q    <= k_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            c_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
          end
        end
        ST_RUN: begin
          if (beat && last_c && last_r && last_k) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_ch     = out_ch_q;
  assign ch_done    = ch_done_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_maxpool_relu.sv
// Self-checking bench for maxpool_relu: directed layers with random data and gaps against an array model.
module tb_maxpool_relu;

  localparam int H     = 28;
  localparam int W     = 28;
  localparam int OC    = 7;
  localparam int DW    = 16;
  localparam int NPOOL = (H / 2) * (W / 2);
  localparam int TOTAL = OC * H * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [7:0]    out_addr;
  logic [2:0]    out_ch;
  logic          ch_done;
  logic          layer_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int img [OC][H][W];

  maxpool_relu #(
    .H(H), .W(W), .OC(OC), .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_ch    (out_ch),
    .ch_done   (ch_done),
    .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Pooled value of window a in channel k; the ramp case uses the closed form.
  function automatic int exp_pool(input int k, input int a, input bit ramp);
    int i, j, m;
    i = a / (W / 2);
    j = a % (W / 2);
    if (ramp) return (2 * i + 1) * W + 2 * j + 1;
    m = relu(img[k][2*i][2*j]);
    if (relu(img[k][2*i][2*j+1]) > m)   m = relu(img[k][2*i][2*j+1]);
    if (relu(img[k][2*i+1][2*j]) > m)   m = relu(img[k][2*i+1][2*j]);
    if (relu(img[k][2*i+1][2*j+1]) > m) m = relu(img[k][2*i+1][2*j+1]);
    return m;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, $signed(out_data), 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_ch"}, out_ch, 0);
    chk({tag, "_chdone"}, ch_done, 0);
    chk({tag, "_ldone"}, layer_done, 0);
  endtask

  task automatic idle_with_valid(input string tag, input int cycles);
    in_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      in_data = DW'($urandom);
      @(posedge clk); #1;
      chk(tag, out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_layer(input string name, input bit ramp, input int max_gap,
                           input bit poke, input int abort_at);
    int n, gap, outs, cds, lds, tail, k, r, c;
    bit e_v, e_cd, e_ld, was_final, beat;
    int e_d, e_a, e_k;
    n = 0; gap = 0; outs = 0; cds = 0; lds = 0; tail = 0;
    e_ld = 0; was_final = 0; e_d = 0; e_a = 0; e_k = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (tail < 4) begin
      beat = 0;
      e_v = 0;
      e_cd = 0;
      e_ld = was_final;
      was_final = 0;
      if (n < TOTAL) begin
        if (abort_at > 0 && n == abort_at) begin
          in_valid = 1'b0;
          start = 1'b0;
          rst = 1'b1;
          #1;
          check_all_zero({name, "_rst"});
          @(posedge clk); #1;
          rst = 1'b0;
          $display("%s: aborted by reset after %0d beats", name, n);
          return;
        end
        if (gap > 0) begin
          gap--;
          in_valid = 1'b0;
          in_data = DW'($urandom);
        end else begin
          k = n / (H * W);
          r = (n / W) % H;
          c = n % W;
          in_valid = 1'b1;
          in_data = img[k][r][c][DW-1:0];
          beat = 1;
          gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            e_v = 1;
            e_a = (r / 2) * (W / 2) + c / 2;
            e_k = k;
            e_d = exp_pool(k, e_a, ramp);
            e_cd = (e_a == NPOOL - 1);
          end
          n++;
          was_final = (n == TOTAL);
        end
        start = poke && ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b1;
        in_data = DW'($urandom);
        start = 1'b0;
        tail++;
      end
      @(posedge clk); #1;
      chk({name, "_valid"}, out_valid, e_v);
      if (e_v) begin
        chk({name, "_data"}, $signed(out_data), e_d);
        chk({name, "_addr"}, out_addr, e_a);
        chk({name, "_ch"}, out_ch, e_k);
      end
      chk({name, "_chdone"}, ch_done, e_cd);
      chk({name, "_ldone"}, layer_done, e_ld);
      if (out_valid === 1'b1) outs++;
      if (ch_done === 1'b1) cds++;
      if (layer_done === 1'b1) lds++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({name, "_n_out"}, outs, OC * NPOOL);
    chk({name, "_n_chdone"}, cds, OC);
    chk({name, "_n_ldone"}, lds, 1);
    $display("%s: %0d pooled outputs, %0d ch_done, %0d layer_done", name, outs, cds, lds);
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < OC; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          case (mode)
            0:       img[k][r][c] = r * W + c;
            1:       img[k][r][c] = -5;
            default: img[k][r][c] = int'($urandom_range(0, 65535)) - 32768;
          endcase
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle_with_valid("idle_in_valid", 5);

    fill(0);
    run_layer("ramp", 1'b1, 0, 1'b0, 0);
    fill(1);
    run_layer("neg5", 1'b0, 0, 1'b0, 0);
    fill(2);
    run_layer("rand_gap", 1'b0, 3, 1'b1, 0);
    fill(2);
    run_layer("abort", 1'b0, 2, 1'b0, 300);
    idle_with_valid("post_rst_idle", 5);
    fill(2);
    run_layer("after_rst", 1'b0, 3, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
